// File: rtl/mfp_uart_transmitter_pkg.sv
// Shared UART definitions: state encodings, data width and baud divisor helper.
package mfp_uart_transmitter_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned uart_divisor(input int unsigned clock_hz,
                                               input int unsigned baud);
    return (clock_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; power-of-two depth, wrap pointers carry an extra MSB.
module mfp_uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mfp_uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (count == (AW + 1)'(DEPTH));

endmodule

// File: rtl/mfp_uart_transmitter.sv
// 8N1 UART transmitter with byte FIFO; define MFP_UART_TRANSMITTER_PARITY_EN to add an even-parity bit.
module mfp_uart_transmitter
  import mfp_uart_transmitter_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [7:0]                    byte_data,
  input  logic                          byte_valid,
  output logic                          byte_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DIVISOR = uart_divisor(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int unsigned CW      = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
  localparam int unsigned BW      = $clog2(DATA_WIDTH);

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("mfp_uart_transmitter: baud divisor must be at least 2");
  end

  uart_state_t           state, state_next;
  logic [CW-1:0]         baud_cnt, baud_next;
  logic [BW-1:0]         bit_idx, bit_next;
  logic [DATA_WIDTH-1:0] shift, shift_next;
  logic                  tx_next;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  baud_last;
`ifdef MFP_UART_TRANSMITTER_PARITY_EN
  logic                  parity, parity_next;
`endif

  mfp_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (byte_valid),
    .push_data (byte_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign byte_ready = !fifo_full;
  assign busy       = (state != IDLE) || (fifo_count != '0);
  assign baud_last  = (baud_cnt == CW'(DIVISOR - 1));

  // tx is registered from the current state, so the line lags the FSM by one clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
`ifdef MFP_UART_TRANSMITTER_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      tx       <= tx_next;
`ifdef MFP_UART_TRANSMITTER_PARITY_EN
      parity   <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next  = state;
    baud_next   = baud_cnt + 1'b1;
    bit_next    = bit_idx;
    shift_next  = shift;
    tx_next     = 1'b1;
    pop         = 1'b0;
`ifdef MFP_UART_TRANSMITTER_PARITY_EN
    parity_next = parity;
`endif
    case (state)
      IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_head;
          bit_next   = '0;
          state_next = START;
`ifdef MFP_UART_TRANSMITTER_PARITY_EN
          parity_next = ^fifo_head;
`endif
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud_last) begin
          baud_next  = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        tx_next = shift[0];
        if (baud_last) begin
          baud_next  = '0;
          shift_next = shift >> 1;
          bit_next   = bit_idx + 1'b1;
          if (bit_idx == BW'(DATA_WIDTH - 1)) begin
`ifdef MFP_UART_TRANSMITTER_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef MFP_UART_TRANSMITTER_PARITY_EN
      PARITY: begin
        tx_next = parity;
        if (baud_last) begin
          baud_next  = '0;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (baud_last) begin
          baud_next = '0;
          // Chain straight into the next frame so back-to-back bytes have no idle gap.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_head;
            bit_next   = '0;
            state_next = START;
`ifdef MFP_UART_TRANSMITTER_PARITY_EN
            parity_next = ^fifo_head;
`endif
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        baud_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

endmodule
